rts_session_controller: RTL and testbench

- Hardware sequencer for the random-test-socket BIST datapath (PRPG, SRSG, MISR, SISA, plus the per-session round controller).
- Steps through NUM_CFG test configurations read from a configuration store: loads polynomials, launches one BIST session per configuration, captures the MISR/SISA signatures and compares them to stored golden signatures.
- Accumulates a pass/fail verdict. Replaces the bench-side configuration loop with on-chip logic.

---
 rtl/rts_pkg.sv | 11 +
 rtl/rts_session_controller_if.sv | 29 ++
 rtl/rts_session_controller_watchdog.sv | 24 ++
 rtl/rts_session_controller.sv | 142 ++++++++++++++
 tb/tb_rts_session_controller.sv | 287 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rts_pkg.sv
// Shared types and default widths for the BIST session sequencer.
package rts_pkg;
  localparam int PRPG_SIZE = 20;
  localparam int SRSG_SIZE = 16;
  localparam int MISR_SIZE = 10;
  localparam int SISA_SIZE = 16;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_APPLY, S_LAUNCH, S_WAIT, S_COMPARE, S_NEXT, S_DONE
  } state_t;
endpackage

// File: rtl/rts_session_controller_if.sv
// Configuration store bus: indexed read request, one-cycle valid with all fields.
interface rts_cfg_if #(
  parameter int CFG_AW    = 2,
  parameter int PRPG_SIZE = rts_pkg::PRPG_SIZE,
  parameter int SRSG_SIZE = rts_pkg::SRSG_SIZE,
  parameter int MISR_SIZE = rts_pkg::MISR_SIZE,
  parameter int SISA_SIZE = rts_pkg::SISA_SIZE
);
  logic                 cfg_rd;
  logic [CFG_AW-1:0]    cfg_addr;
  logic                 cfg_valid;
  logic [PRPG_SIZE-1:0] cfg_prpg_poly;
  logic [SRSG_SIZE-1:0] cfg_srsg_poly;
  logic [MISR_SIZE-1:0] cfg_misr_poly;
  logic [SISA_SIZE-1:0] cfg_sisa_poly;
  logic [MISR_SIZE-1:0] cfg_gold_misr;
  logic [SISA_SIZE-1:0] cfg_gold_sisa;

  modport master (
    output cfg_rd, cfg_addr,
    input  cfg_valid, cfg_prpg_poly, cfg_srsg_poly, cfg_misr_poly,
           cfg_sisa_poly, cfg_gold_misr, cfg_gold_sisa
  );
  modport slave (
    input  cfg_rd, cfg_addr,
    output cfg_valid, cfg_prpg_poly, cfg_srsg_poly, cfg_misr_poly,
           cfg_sisa_poly, cfg_gold_misr, cfg_gold_sisa
  );
endinterface

// File: rtl/rts_session_controller_watchdog.sv
// Per-configuration WAIT watchdog: clearable up-counter with terminal-count flag.
module rts_watchdog #(
  parameter int TIMEOUT_CYC = 2048,
  parameter int TMR_W       = 12
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tc
);
  localparam logic [TMR_W-1:0] TC_VAL = TMR_W'(TIMEOUT_CYC - 1);

  logic [TMR_W-1:0] cnt;

  // Count WAIT cycles; the FSM leaves WAIT at terminal count so no wrap guard is needed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   cnt <= '0;
    else if (clr) cnt <= '0;
    else if (en)  cnt <= cnt + 1'b1;
  end

  assign tc = (cnt == TC_VAL);
endmodule

// File: rtl/rts_session_controller.sv
// Session sequencer: fetch each config, apply polys, launch a BIST round,
// wait for completion (with watchdog), compare signatures, accumulate verdict.
module rts_session_controller #(
  parameter int PRPG_SIZE   = rts_pkg::PRPG_SIZE,
  parameter int SRSG_SIZE   = rts_pkg::SRSG_SIZE,
  parameter int MISR_SIZE   = rts_pkg::MISR_SIZE,
  parameter int SISA_SIZE   = rts_pkg::SISA_SIZE,
  parameter int NUM_CFG     = 4,
  parameter int CFG_AW      = 2,
  parameter int TIMEOUT_CYC = 2048,
  parameter int TMR_W       = 12
) (
  input  logic                 clk,
  input  logic                 masterRst_n,
  input  logic                 start,
  rts_cfg_if.master            cfg,
  output logic [PRPG_SIZE-1:0] PRPG_Poly,
  output logic [SRSG_SIZE-1:0] SRSG_Poly,
  output logic [MISR_SIZE-1:0] MISR_Poly,
  output logic [SISA_SIZE-1:0] SISA_Poly,
  output logic                 rts_start,
  input  logic                 rts_done,
  input  logic [MISR_SIZE-1:0] MISR_Out,
  input  logic [SISA_SIZE-1:0] SISA_Out,
  output logic                 busy,
  output logic                 session_done,
  output logic                 pass,
  output logic [CFG_AW:0]      fail_count,
  output logic [CFG_AW-1:0]    first_fail_idx,
  output logic                 timeout_err
);
  import rts_pkg::*;

  localparam logic [CFG_AW-1:0] LAST_IDX = CFG_AW'(NUM_CFG - 1);
  localparam logic [CFG_AW:0]   FC_MAX   = (CFG_AW+1)'(NUM_CFG);

  state_t               state, state_nxt;
  logic [CFG_AW-1:0]    idx;
  logic                 done_q, done_rise;
  logic                 wd_tc, wd_timeout, mismatch, cfg_fail;
  logic [MISR_SIZE-1:0] gold_misr;
  logic [SISA_SIZE-1:0] gold_sisa;

  assign done_rise  = rts_done & ~done_q;
  assign mismatch   = ({MISR_Out, SISA_Out} != {gold_misr, gold_sisa});
  // done_rise beats the terminal count on the same cycle
  assign wd_timeout = (state == S_WAIT) && wd_tc && !done_rise;
  assign cfg_fail   = ((state == S_COMPARE) && mismatch) || wd_timeout;

  assign cfg.cfg_rd   = (state == S_FETCH);
  assign cfg.cfg_addr = idx;
  assign rts_start    = (state == S_LAUNCH);

  rts_watchdog #(.TIMEOUT_CYC(TIMEOUT_CYC), .TMR_W(TMR_W)) u_wd (
    .clk   (clk),
    .rst_n (masterRst_n),
    .clr   (state == S_LAUNCH),
    .en    (state == S_WAIT),
    .tc    (wd_tc)
  );

  // State register
  always_ff @(posedge clk or negedge masterRst_n) begin
    if (!masterRst_n) state <= S_IDLE;
    else              state <= state_nxt;
  end

  // Next-state logic; DONE accepts a new start exactly like IDLE
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE, S_DONE: if (start)     state_nxt = S_FETCH;
      S_FETCH:        if (cfg.cfg_valid) state_nxt = S_APPLY;
      S_APPLY:        state_nxt = S_LAUNCH;
      S_LAUNCH:       state_nxt = S_WAIT;
      S_WAIT: begin
        if (done_rise)  state_nxt = S_COMPARE;
        else if (wd_tc) state_nxt = S_NEXT;
      end
      S_COMPARE:      state_nxt = S_NEXT;
      S_NEXT:         state_nxt = (idx == LAST_IDX) ? S_DONE : S_FETCH;
      default:        state_nxt = S_IDLE;
    endcase
  end

  // Config capture, index, edge-detect history and verdict accumulation
  always_ff @(posedge clk or negedge masterRst_n) begin
    if (!masterRst_n) begin
      done_q         <= 1'b0;
      idx            <= '0;
      PRPG_Poly      <= '0;
      SRSG_Poly      <= '0;
      MISR_Poly      <= '0;
      SISA_Poly      <= '0;
      gold_misr      <= '0;
      gold_sisa      <= '0;
      busy           <= 1'b0;
      session_done   <= 1'b0;
      pass           <= 1'b0;
      fail_count     <= '0;
      first_fail_idx <= '0;
      timeout_err    <= 1'b0;
    end else begin
      done_q <= rts_done;
      case (state)
        S_IDLE, S_DONE: if (start) begin
          fail_count     <= '0;
          first_fail_idx <= '0;
          timeout_err    <= 1'b0;
          pass           <= 1'b0;
          session_done   <= 1'b0;
          idx            <= '0;
          busy           <= 1'b1;
        end
        S_FETCH: if (cfg.cfg_valid) begin
          PRPG_Poly <= cfg.cfg_prpg_poly;
          SRSG_Poly <= cfg.cfg_srsg_poly;
          MISR_Poly <= cfg.cfg_misr_poly;
          SISA_Poly <= cfg.cfg_sisa_poly;
          gold_misr <= cfg.cfg_gold_misr;
          gold_sisa <= cfg.cfg_gold_sisa;
        end
        S_NEXT: begin
          if (idx == LAST_IDX) begin
            busy         <= 1'b0;
            session_done <= 1'b1;
            pass         <= (fail_count == '0) && !timeout_err;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        default: ;
      endcase
      // Mismatch and timeout are scored the same way
      if (cfg_fail) begin
        if (fail_count != FC_MAX) fail_count <= fail_count + 1'b1;
        if (fail_count == '0)     first_fail_idx <= idx;
      end
      if (wd_timeout) timeout_err <= 1'b1;
    end
  end
endmodule

// File: tb/tb_rts_session_controller.sv
// Scoreboard bench: config store and round-controller models drive the DUT,
// a session-level reference model predicts launches and verdicts.
module tb_rts_session_controller;
  localparam int NC = 4, AW = 2, TO = 2048, TW = 12;
  localparam int PW = 20, SW = 16, MW = 10, QW = 16;
  localparam int NEVER = 1000000;
  localparam int SESS_BOUND = NC * (TO + 100) + 200;

  typedef struct packed {
    logic [PW-1:0] p; logic [SW-1:0] s; logic [MW-1:0] m; logic [QW-1:0] q;
  } polys_t;
  typedef struct packed {
    logic pass; logic [AW:0] fc; logic [AW-1:0] ffi; logic to;
  } verd_t;

  logic clk = 1'b0, masterRst_n = 1'b0, start = 1'b0, rts_done = 1'b0;
  logic [MW-1:0] MISR_Out = '0;
  logic [QW-1:0] SISA_Out = '0;
  logic [PW-1:0] PRPG_Poly;
  logic [SW-1:0] SRSG_Poly;
  logic [MW-1:0] MISR_Poly;
  logic [QW-1:0] SISA_Poly;
  logic rts_start, busy, session_done, pass, timeout_err;
  logic [AW:0] fail_count;
  logic [AW-1:0] first_fail_idx;

  rts_cfg_if #(.CFG_AW(AW), .PRPG_SIZE(PW), .SRSG_SIZE(SW), .MISR_SIZE(MW), .SISA_SIZE(QW)) cfg_bus ();

  rts_session_controller #(
    .PRPG_SIZE(PW), .SRSG_SIZE(SW), .MISR_SIZE(MW), .SISA_SIZE(QW),
    .NUM_CFG(NC), .CFG_AW(AW), .TIMEOUT_CYC(TO), .TMR_W(TW)
  ) dut (
    .clk(clk), .masterRst_n(masterRst_n), .start(start), .cfg(cfg_bus),
    .PRPG_Poly(PRPG_Poly), .SRSG_Poly(SRSG_Poly), .MISR_Poly(MISR_Poly), .SISA_Poly(SISA_Poly),
    .rts_start(rts_start), .rts_done(rts_done), .MISR_Out(MISR_Out), .SISA_Out(SISA_Out),
    .busy(busy), .session_done(session_done), .pass(pass), .fail_count(fail_count),
    .first_fail_idx(first_fail_idx), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  // per-session config table and round-controller plan
  polys_t        tab_poly [NC];
  logic [MW-1:0] tab_gm [NC];
  logic [QW-1:0] tab_gs [NC];
  int            dly [NC], lat [NC], hold [NC];
  logic [MW-1:0] em [NC];
  logic [QW-1:0] es [NC];

  polys_t lq [$];
  verd_t  vq [$];
  int     fq [$];
  int     launch_n = 0;
  int     checks = 0, failures = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [127:0] all_outs();
    return {cfg_bus.cfg_rd, cfg_bus.cfg_addr, PRPG_Poly, SRSG_Poly, MISR_Poly, SISA_Poly,
            rts_start, busy, session_done, pass, fail_count, first_fail_idx, timeout_err};
  endfunction

  task automatic new_table(input int l);
    for (int i = 0; i < NC; i++) begin
      tab_poly[i] = polys_t'({$urandom, $urandom});
      tab_gm[i] = MW'($urandom);
      tab_gs[i] = QW'($urandom);
      dly[i] = 0; lat[i] = l; hold[i] = 0; em[i] = '0; es[i] = '0;
    end
  endtask

  task automatic rand_plan();
    int r;
    new_table(1);
    for (int i = 0; i < NC; i++) begin
      r = $urandom_range(0, 15);
      dly[i] = $urandom_range(0, 3);
      lat[i] = $urandom_range(1, 40);
      if (r == 0) lat[i] = TO + $urandom_range(0, 1);
      if (r == 1 || r == 2) begin hold[i] = $urandom_range(1, 4); lat[i] = hold[i] + 3; end
      if (r == 3 || r == 4) em[i] = MW'(1) << $urandom_range(0, MW-1);
      if (r == 5) es[i] = QW'(1) << $urandom_range(0, QW-1);
    end
  endtask

  // Reference: a config fails if its round never completes within TO WAIT
  // cycles (done rise L cycles after launch is seen iff L <= TO) or its
  // signature differs from golden.
  task automatic push_session();
    int fc, ff; bit tmo, t;
    verd_t v;
    fc = 0; ff = 0; tmo = 0;
    for (int i = 0; i < NC; i++) begin
      lq.push_back(tab_poly[i]);
      fq.push_back(i);
      t = (lat[i] > TO);
      if (t) tmo = 1;
      if (t || em[i] != 0 || es[i] != 0) begin
        if (fc == 0) ff = i;
        fc++;
      end
    end
    v.pass = (fc == 0) && !tmo;
    v.fc = (AW+1)'(fc);
    v.ffi = AW'(ff);
    v.to = tmo;
    vq.push_back(v);
  endtask

  task automatic clear_sb();
    lq.delete(); vq.delete(); fq.delete();
  endtask

  // Config store: answers cfg_rd after dly cycles with a one-cycle valid
  initial begin
    int w, k;
    w = 0;
    cfg_bus.cfg_valid = 1'b0;
    forever begin
      @(negedge clk);
      cfg_bus.cfg_prpg_poly = PW'($urandom); cfg_bus.cfg_srsg_poly = SW'($urandom);
      cfg_bus.cfg_misr_poly = MW'($urandom); cfg_bus.cfg_sisa_poly = QW'($urandom);
      cfg_bus.cfg_gold_misr = MW'($urandom); cfg_bus.cfg_gold_sisa = QW'($urandom);
      if (!masterRst_n) begin
        w = 0; cfg_bus.cfg_valid = 1'b0;
      end else if (cfg_bus.cfg_valid) begin
        cfg_bus.cfg_valid = 1'b0;
      end else if (cfg_bus.cfg_rd) begin
        chk("fetch_expected", fq.size() != 0, 1);
        if (fq.size() != 0) begin
          k = fq[0];
          chk("cfg_addr", cfg_bus.cfg_addr, k);
          if (w == dly[k]) begin
            cfg_bus.cfg_valid = 1'b1;
            {cfg_bus.cfg_prpg_poly, cfg_bus.cfg_srsg_poly, cfg_bus.cfg_misr_poly, cfg_bus.cfg_sisa_poly} = tab_poly[k];
            cfg_bus.cfg_gold_misr = tab_gm[k];
            cfg_bus.cfg_gold_sisa = tab_gs[k];
            void'(fq.pop_front());
            w = 0;
          end else w++;
        end
      end else if (w != 0) begin
        chk("cfg_rd_held_until_valid", cfg_bus.cfg_rd, 1);
        w = 0;
      end
    end
  end

  // Round controller: restart on rts_start, raise done per plan
  initial begin
    int t, k; bit active;
    t = 0; k = 0; active = 0;
    forever begin
      @(negedge clk);
      if (!masterRst_n) begin
        active = 0; rts_done = 1'b0;
      end else if (rts_start) begin
        k = (launch_n < NC) ? launch_n : NC - 1;
        launch_n++;
        t = 0; active = 1;
        rts_done = (hold[k] != 0);
        MISR_Out = ~tab_gm[k]; SISA_Out = ~tab_gs[k];
      end else if (active) begin
        t++;
        if (hold[k] != 0 && t == hold[k]) rts_done = 1'b0;
        if (t == lat[k]) begin
          rts_done = 1'b1;
          MISR_Out = tab_gm[k] ^ em[k];
          SISA_Out = tab_gs[k] ^ es[k];
        end
      end
    end
  end

  // Monitor: pops expectations on each launch and on session completion
  initial begin
    bit prs, psd; polys_t e; verd_t v;
    prs = 0; psd = 0;
    forever begin
      @(negedge clk);
      if (!masterRst_n) begin
        prs = 0; psd = 0;
      end else begin
        if (rts_start) begin
          chk("rts_start_single_cycle", prs, 0);
          chk("rts_start_not_in_fetch", cfg_bus.cfg_rd, 0);
          chk("launch_expected", lq.size() != 0, 1);
          if (lq.size() != 0) begin
            e = lq.pop_front();
            chk("launch_polys", {PRPG_Poly, SRSG_Poly, MISR_Poly, SISA_Poly}, e);
          end
        end
        if (session_done && !psd) begin
          chk("done_expected", vq.size() != 0, 1);
          if (vq.size() != 0) begin
            v = vq.pop_front();
            chk("verdict_pass_fc_ffi_to", {pass, fail_count, first_fail_idx, timeout_err}, v);
            chk("busy_low_at_done", busy, 0);
            chk("all_launches_seen", lq.size(), 0);
          end
        end
        prs = rts_start; psd = session_done;
      end
    end
  end

  task automatic recover();
    masterRst_n = 1'b0;
    @(negedge clk);
    clear_sb();
    #2 masterRst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic run_session(input bit poke_busy);
    int n; bit poked;
    launch_n = 0;
    push_session();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_start", busy, 1);
    n = 0; poked = 0;
    while (!session_done && n < SESS_BOUND) begin
      @(negedge clk); n++;
      if (poke_busy && !poked && launch_n == 2) begin
        start = 1'b1; @(negedge clk); start = 1'b0; poked = 1;
      end
    end
    chk("session_done_within_bound", session_done, 1);
    if (!session_done) recover();
    else begin
      repeat (3) @(negedge clk);
      chk("done_held", {session_done, busy}, 2'b10);
      chk("polys_held", {PRPG_Poly, SRSG_Poly, MISR_Poly, SISA_Poly}, tab_poly[NC-1]);
    end
  endtask

  initial begin
    int n;
    new_table(20);
    repeat (3) @(negedge clk);
    chk("reset_outputs", all_outs(), 0);
    masterRst_n = 1'b1;
    @(negedge clk);

    new_table(20); run_session(0);                              // all pass
    new_table(20); em[2] = 10'h001; run_session(0);             // mismatch on cfg 2
    new_table(20); lat[1] = NEVER; run_session(0);              // timeout on cfg 1
    new_table(20); dly[0] = 5; run_session(0);                  // slow fetch
    new_table(20); hold[0] = 4; lat[0] = 7; lat[1] = TO;        // stale level, terminal-count rise
    run_session(0);
    new_table(20); lat[3] = TO + 1; run_session(0);             // one cycle too late
    new_table(15); run_session(1);                              // start while busy

    // reset during WAIT of config 2
    new_table(30);
    launch_n = 0;
    push_session();
    start = 1'b1; @(negedge clk); start = 1'b0;
    n = 0;
    while (launch_n < 3 && n < 500) begin @(negedge clk); n++; end
    chk("reached_cfg2_launch", launch_n, 3);
    repeat (5) @(negedge clk);
    #2 masterRst_n = 1'b0;
    #1 chk("reset_midsession_outputs", all_outs(), 0);
    clear_sb();
    @(negedge clk);
    #2 masterRst_n = 1'b1;
    @(negedge clk);
    chk("idle_after_reset", {busy, session_done, cfg_bus.cfg_rd}, 0);

    for (int s = 0; s < 6; s++) begin
      rand_plan();
      run_session(0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
